// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants and the request-kind enumeration
// used by the instruction encoder.
package rv_isa_pkg;

    typedef enum logic [1:0] {
        KIND_ADD  = 2'd0,
        KIND_SUB  = 2'd1,
        KIND_ADDI = 2'd2,
        KIND_RSVD = 2'd3
    } kind_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    // Queue word: {illegal flag, 32-bit instruction}
    localparam int ENC_W = 33;

endpackage

// File: rtl/rv_enc_fifo.sv
// Circular FIFO holding encoded words; flush clears it synchronously and
// wins over push/pop. The head reads as zero while the queue is empty.
module rv_enc_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Fullness is judged before any same-cycle pop, so a full queue stays closed
    assign w_push  = i_push && (r_cnt != FULL_CNT) && !flush;
    assign w_pop   = i_pop && (r_cnt != '0) && !flush;
    assign o_full  = (r_cnt == FULL_CNT);
    assign o_valid = (r_cnt != '0);
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// RV32I ADD/SUB/ADDI encoder feeding a DEPTH-word output queue.
// Macro RV_ENC_ITYPE_EN enables ADDI encoding; otherwise kind 2 is illegal.
module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [11:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_code,
    output logic        out_illegal,
    output logic [7:0]  illegal_cnt
);

    kind_e             w_kind;
    logic [31:0]       w_code;
    logic              w_illegal;
    logic              w_push;
    logic              w_full;
    logic [ENC_W-1:0]  w_head;
    logic [7:0]        r_illegal_cnt;

    assign w_kind = kind_e'(in_kind);

    always_comb begin
        w_code    = '0;
        w_illegal = 1'b0;
        case (w_kind)
            KIND_ADD: w_code = {F7_ADD, in_rs2, in_rs1, F3_ADD, in_rd, OP_RTYPE};
            KIND_SUB: w_code = {F7_SUB, in_rs2, in_rs1, F3_ADD, in_rd, OP_RTYPE};
`ifdef RV_ENC_ITYPE_EN
            KIND_ADDI: w_code = {in_imm, in_rs1, F3_ADD, in_rd, OP_ITYPE};
`endif
            default: w_illegal = 1'b1;
        endcase
    end

`ifndef RV_ENC_ITYPE_EN
    logic w_unused_imm;
    assign w_unused_imm = ^in_imm;
`endif

    assign in_ready = !w_full;
    // A flushed request is dropped, so it neither enters the queue nor counts
    assign w_push   = in_valid && !w_full && !flush;

    rv_enc_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .i_push  (w_push),
        .i_data  ({w_illegal, w_code}),
        .i_pop   (out_ready),
        .o_full  (w_full),
        .o_valid (out_valid),
        .o_data  (w_head)
    );

    assign out_code    = w_head[31:0];
    assign out_illegal = w_head[32];
    assign illegal_cnt = r_illegal_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_push && w_illegal && (r_illegal_cnt != 8'hFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Randomized bench for rv_instr_encoder against a queue-based reference model,
// with literal expectations pinning the encodings and boundary behaviour.
module tb_rv_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [11:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_code;
    logic        out_illegal;
    logic [7:0]  illegal_cnt;

    always #5 clk = ~clk;

    rv_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] mq[$];
    int          mcnt = 0;
    bit          chk_en = 0;

`ifdef RV_ENC_ITYPE_EN
    localparam bit ITYPE = 1'b1;
`else
    localparam bit ITYPE = 1'b0;
`endif

    // Reference encoding from field positions: rs2 at bit 20, rs1 at 15, rd at 7
    function automatic logic [32:0] ref_word(input logic [1:0] kind, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [11:0] imm);
        int unsigned base;
        int unsigned immv;
        base = 32'(rs1) * 32768 + 32'(rd) * 128;
        immv = 32'(imm) * 1048576;
        if (kind == 2'd0) return {1'b0, base + 32'(rs2) * 1048576 + 51};
        if (kind == 2'd1) return {1'b0, 32'h4000_0000 + base + 32'(rs2) * 1048576 + 51};
        if (kind == 2'd2 && ITYPE) return {1'b0, immv + base + 19};
        return {1'b1, 32'h0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state advances on the same edges as the DUT
    initial begin
        bit          m_pop;
        bit          m_push;
        logic [32:0] w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mcnt = 0;
            end else if (flush) begin
                mq.delete();
            end else begin
                m_pop  = (mq.size() > 0) && out_ready;
                m_push = in_valid && (mq.size() < DEPTH);
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    w = ref_word(in_kind, in_rd, in_rs1, in_rs2, in_imm);
                    mq.push_back(w);
                    if (w[32] && mcnt < 255) mcnt++;
                end
            end
        end
    end

    // Compare process: every falling edge outside reset
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
                chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
                chk("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
                if (mq.size() > 0) begin
                    chk("out_code", out_code, mq[0][31:0]);
                    chk("out_illegal", 32'(out_illegal), 32'(mq[0][32]));
                end
            end
        end
    end

    task automatic set_req(input bit v, input logic [1:0] k, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        in_valid = v;
        in_kind  = k;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_req($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom),
                    5'($urandom), 5'($urandom), 12'($urandom));
            out_ready = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0;
    endtask

    initial begin
        int base_cnt;
        rst_n     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_req(0, 2'd0, 5'd0, 5'd0, 5'd0, 12'd0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_code", out_code, 32'h0);
        chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);

        // Single encodings, one cycle latency
        out_ready = 1'b1;
        set_req(1, 2'd0, 5'd3, 5'd1, 5'd2, 12'd0);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_code", out_code, 32'h0020_81B3);
        chk("add_illegal", 32'(out_illegal), 32'd0);
        set_req(1, 2'd1, 5'd5, 5'd6, 5'd7, 12'd0);
        step();
        chk("sub_code", out_code, 32'h4073_02B3);
        set_req(1, 2'd2, 5'd1, 5'd0, 5'd0, 12'hFFF);
        step();
        chk("addi_code", out_code, ITYPE ? 32'hFFF0_0093 : 32'h0);
        chk("addi_illegal", 32'(out_illegal), ITYPE ? 32'd0 : 32'd1);
        set_req(0, 2'd0, 5'd0, 5'd0, 5'd0, 12'd0);
        step();
        chk("drained_valid", 32'(out_valid), 32'd0);
        base_cnt = ITYPE ? 0 : 1;
        chk("cnt_after_addi", 32'(illegal_cnt), 32'(base_cnt));

        // Fill to DEPTH with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 2'd0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 12'd0);
            step();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_code, 32'h0031_00B3);
        set_req(1, 2'd1, 5'd9, 5'd9, 5'd9, 12'd0);
        step();
        chk("fifth_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("after_pop_ready", 32'(in_ready), 32'd1);
        step();
        set_req(0, 2'd0, 5'd0, 5'd0, 5'd0, 12'd0);
        repeat (6) step();
        chk("full_drained", 32'(out_valid), 32'd0);

        // Flush with three words queued and an illegal request pending
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1, 2'd0, 5'($urandom), 5'($urandom), 5'($urandom), 12'd0);
            step();
        end
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        set_req(1, 2'd3, 5'd1, 5'd1, 5'd1, 12'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_req(0, 2'd0, 5'd0, 5'd0, 5'd0, 12'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_cnt", 32'(illegal_cnt), 32'(base_cnt));
        chk("flush_ready", 32'(in_ready), 32'd1);
        step();
        chk("flush_dropped", 32'(out_valid), 32'd0);

        // Saturation of the illegal counter
        out_ready = 1'b1;
        set_req(1, 2'd3, 5'd2, 5'd3, 5'd4, 12'h123);
        repeat (300) step();
        set_req(0, 2'd0, 5'd0, 5'd0, 5'd0, 12'd0);
        repeat (2) step();
        chk("cnt_saturated", 32'(illegal_cnt), 32'd255);

        rand_cycles(2000);

        // Asynchronous reset between clock edges with words queued
        out_ready = 1'b0;
        set_req(1, 2'd3, 5'd1, 5'd2, 5'd3, 12'd0);
        repeat (3) step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_code", out_code, 32'h0);
        chk("arst_illegal", 32'(out_illegal), 32'd0);
        chk("arst_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        set_req(0, 2'd0, 5'd0, 5'd0, 5'd0, 12'd0);
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        rand_cycles(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_instr_encoder.md
RV_INSTR_ENCODER -- requirements
Module: rv_instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output queue depth in words (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous queue clear.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-007 SHALL have port in_kind  input  2  0=ADD, 1=SUB, 2=ADDI, 3=reserved.
REQ-008 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 SHALL have port in_imm  input  12  ADDI immediate, two's complement.
REQ-010 SHALL have port out_valid  output  1  queue head valid.
REQ-011 SHALL have port out_ready  input  1  head consumed when out_valid&&out_ready.
REQ-012 SHALL have port out_code  output  32  encoded RV32I instruction word.
REQ-013 SHALL have port out_illegal  output  1  head came from an unencodable request.
REQ-014 SHALL have port illegal_cnt  output  8  saturating count of illegal requests accepted.

Function
REQ-015 SHALL encode ADD as {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}.
REQ-016 SHALL encode SUB as ADD but with funct7 = 7'b0100000.
REQ-017 SHALL encode ADDI as {imm[11:0], rs1, 3'b000, rd, 7'b0010011}; in_rs2 is ignored.
REQ-018 SHALL queue an illegal request (kind 3) with out_code = 32'h0 and out_illegal = 1.
REQ-019 SHALL encode combinationally at accept and write the result into a DEPTH-entry circular FIFO.
REQ-020 SHALL assert out_valid one cycle after a request is accepted into an empty queue; no same-cycle pass-through.
REQ-021 SHALL drive in_ready = (count < DEPTH); a pop in the same cycle does not raise in_ready while full.
REQ-022 SHALL allow a simultaneous push and pop when not full and not empty: count unchanged, order preserved.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL hold out_code and out_illegal stable while out_valid && !out_ready.
REQ-025 SHALL give flush priority over push and pop: count = 0, pointers = 0, and any same-cycle request is dropped; illegal_cnt unaffected.
REQ-026 SHALL increment illegal_cnt on each accepted illegal request and hold it at 255.

Reset
REQ-027 SHALL, on rst_n low, clear immediately: count, pointers, out_valid = 0, illegal_cnt = 0, out_code = 0, out_illegal = 0.
REQ-028 SHALL drive in_ready = 1 on the first cycle after reset release; an asserted reset mid-stream discards all queued words.

Configuration
REQ-029 SHALL honour macro RV_ENC_ITYPE_EN: when defined, kind 2 is encoded per REQ-017; when undefined, kind 2 is treated as illegal per REQ-018 and REQ-026.

Structure
REQ-030 SHALL take opcode constants (OP_RTYPE, OP_ITYPE), funct3/funct7 constants and the kind enumeration from shared package rv_isa_pkg.
REQ-031 SHALL place queue storage and pointers in sub-module rv_enc_fifo (parameterised by DEPTH and width 33), with encode logic in the top level.

Verification
REQ-032 SHALL cover: ADD rd=3 rs1=1 rs2=2, out_ready=1 -> out_code 0x002081B3 one cycle later, out_illegal 0.
REQ-033 SHALL cover: SUB rd=5 rs1=6 rs2=7 -> 0x407302B3; ADDI rd=1 rs1=0 imm=0xFFF -> 0xFFF00093 (macro defined), or illegal with word 0x00000000 (macro undefined).
REQ-034 SHALL cover: DEPTH=4, out_ready=0, five back-to-back requests -> in_ready low after the 4th; then out_ready=1 -> four words drained in FIFO order, the 5th request accepted after the first pop.
REQ-035 SHALL cover: 300 kind-3 requests -> illegal_cnt saturates at 255, every word has out_illegal=1.
REQ-036 SHALL cover: flush asserted with three words queued and in_valid high -> out_valid 0 next cycle, the request dropped, illegal_cnt unchanged.
REQ-037 SHALL cover: rst_n pulsed low mid-stream, between clock edges -> outputs cleared asynchronously, in_ready 1 after release.
